fle_cfg_bank_loader: RTL and testbench
======================================

// Module: fle_cfg_bank_loader
// PURPOSE
//  Memory-bank configuration sequencer for one physical FLE/fabric tile (frac_lut6 + adder_carry + 2x ff_bypass + 2 D-muxes).
//  Accepts a serial config bitstream over a valid/ready handshake and assembles it into a NUM_BITS-wide bl image.
//  Then writes the image into the tile one cell at a time: one-hot wl pulses, bl held stable throughout.
//  Sits between the chip-level programming interface and the tile's bl/wl inputs; runs on the programming clock.
// PARAMETERS
//  NUM_BITS      70  config cells in tile (bl/wl width); bit map: [0:63] LUT, [64:67] ff_bypass, [68:69] D-mux sram
//  BL_SETUP_CYC  1   cycles bl held stable with wl=0 before first wl pulse (>=1)
//  WL_PULSE_CYC  2   cycles each wl[i] held high (>=1)
//  WL_GAP_CYC    1   cycles all-wl-low between consecutive pulses (>=1)
// PORTS
//  prog_clk    in   1         programming clock; all state on rising edge
//  prog_reset  in   1         asynchronous, active-high reset
//  start       in   1         1-cycle request to begin a load; sampled in IDLE only
//  abort       in   1         level; forces return to IDLE, highest priority after reset
//  cfg_bit     in   1         serial config data, bit 0 first
//  cfg_valid   in   1         cfg_bit valid
//  cfg_ready   out  1         loader accepts cfg_bit this cycle (transfer = valid & ready)
//  bl          out  NUM_BITS  bit-line image to tile, [0:NUM_BITS-1]
//  wl          out  NUM_BITS  word lines to tile, one-hot or zero
//  busy        out  1         high in LOAD/SETUP/WRITE
//  done        out  1         1-cycle pulse: full image written
//  aborted     out  1         1-cycle pulse: abort taken while busy
// BEHAVIOUR
//  Reset: state=IDLE; bl=0, wl=0, cfg_ready=0, busy=0, done=0, aborted=0; counters=0.
//  All outputs registered; no combinational path from any input to any output.
//  States: IDLE -> LOAD -> SETUP -> WRITE -> DONE -> IDLE.
//   IDLE:  start=1 -> LOAD, bit_cnt=0. start=0 -> stay. bl retains last written image.
//   LOAD:  cfg_ready=1. Each transfer writes bl[bit_cnt] and increments bit_cnt.
//          The transfer with bit_cnt==NUM_BITS-1 -> SETUP; cfg_ready=0 from the next cycle.
//          cfg_valid=0 stalls with no timeout; bits not yet loaded keep their previous value.
//   SETUP: wl=0 for BL_SETUP_CYC cycles -> WRITE, cell_idx=0.
//   WRITE: per cell_idx: wl[cell_idx]=1 for WL_PULSE_CYC cycles, then wl=0 for WL_GAP_CYC cycles; cell_idx++.
//          After the gap of cell NUM_BITS-1 -> DONE. Never more than one wl bit high in any cycle.
//   DONE:  done=1 for exactly one cycle -> IDLE.
//  Timing: last accepted bit at cycle T -> first wl high at T+1+BL_SETUP_CYC.
//          Defaults: done high at T+1+1+70*3 = T+212.
//  bl is constant from SETUP entry through DONE; it changes only on LOAD transfers.
//  Abort while busy: next edge state=IDLE, wl=0, cfg_ready=0, aborted=1 for 1 cycle, done=0.
//   bl keeps its partial image. Abort in IDLE/DONE: no effect (DONE still pulses).
//  start while busy: ignored. start and abort in the same IDLE cycle: abort wins, stay IDLE, aborted=0.
//  Async reset mid-WRITE: wl drops to 0 immediately (asynchronously); all outputs take reset values.
//  Counters: bit_cnt and cell_idx are $clog2(NUM_BITS) wide; the pulse/gap timer is wide enough for
//   max(BL_SETUP_CYC, WL_PULSE_CYC, WL_GAP_CYC). No wrap occurs: terminal compares use ==NUM_BITS-1.
// STRUCTURE
//  Package fle_cfg_pkg: state enum (IDLE, LOAD, SETUP, WRITE, DONE).
//   Also holds the default localparams FLE_CFG_BITS=70 and the LUT/FF/MUX bit-range constants.
//  Sub-module fle_cfg_wl_sequencer: given go, NUM_BITS, pulse/gap counts, drives one-hot wl and a last_done strobe.
//   It contains cell_idx and the pulse/gap timer. The top level holds the FSM, the bl shift/index register and the handshake.
// TESTING
//  1 Reset: hold prog_reset 3 cycles -> all outputs 0; release, no start -> stay idle, wl=0, 100 cycles.
//  2 Nominal: start; stream 70 bits with back-to-back valid, pattern bit i = i%3==0.
//    -> bl matches pattern; wl[i] high exactly 2 cycles at T+2+3i; wl always one-hot or zero;
//       done pulses once at T+212; busy falls the same cycle done is seen.
//  3 Stalled stream: insert random valid gaps (up to 10 cycles) -> bl image identical to test 2;
//    WRITE timing referenced to the last transfer.
//  4 Abort mid-WRITE at cell 30 -> wl=0 next cycle, aborted 1 cycle, no done.
//    Restart with all-ones image -> full sequence, bl=all ones.
//  5 Async reset asserted between clock edges while wl[40]=1 -> wl=0 before the next edge; FSM IDLE after release.
//  6 start pulsed during LOAD/WRITE and start+abort together in IDLE -> ignored; no extra done, no aborted pulse.

Source files
------------

// File: rtl/fle_cfg_pkg.sv
// Shared types and default geometry for the FLE tile configuration loader.
package fle_cfg_pkg;

   // Default tile geometry: config cells and their bit ranges in the bl/wl image
   localparam int unsigned FLE_CFG_BITS = 70;
   localparam int unsigned LUT_LSB      = 0;
   localparam int unsigned LUT_MSB      = 63;
   localparam int unsigned FFB_LSB      = 64;
   localparam int unsigned FFB_MSB      = 67;
   localparam int unsigned DMUX_LSB     = 68;
   localparam int unsigned DMUX_MSB     = 69;

   // Loader sequencing states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SETUP = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_e;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fle_cfg_wl_sequencer.sv
// Walks the word lines one cell at a time: pulse wl[idx] high, then hold all low for a gap.
module fle_cfg_wl_sequencer
   import fle_cfg_pkg::*;
#(
   parameter int unsigned NUM_BITS  = FLE_CFG_BITS,
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned GAP_CYC   = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                go_i,
   input  logic                clr_i,
   output logic [NUM_BITS-1:0] wl_o,
   output logic                last_done_c_o
);

   localparam int unsigned IDX_W = cnt_width(NUM_BITS);
   localparam int unsigned TMR_W = cnt_width((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);

   logic                active_q, active_d;
   logic                pulse_q, pulse_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W-1:0]    idx_nxt;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [NUM_BITS-1:0] wl_q, wl_d;
   logic                pulse_end;
   logic                gap_end;
   logic                last_cell;

   // Sequencer registers; wl drops asynchronously on reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         pulse_q  <= 1'b0;
         idx_q    <= '0;
         tmr_q    <= '0;
         wl_q     <= '0;
      end else begin
         active_q <= active_d;
         pulse_q  <= pulse_d;
         idx_q    <= idx_d;
         tmr_q    <= tmr_d;
         wl_q     <= wl_d;
      end
   end

   // Pulse/gap timing and cell advance; wl is cleared at the end of every pulse so it is never multi-hot
   always_comb begin
      active_d  = active_q;
      pulse_d   = pulse_q;
      idx_d     = idx_q;
      tmr_d     = tmr_q;
      wl_d      = wl_q;
      idx_nxt   = idx_q + IDX_W'(1);
      pulse_end = (tmr_q == TMR_W'(PULSE_CYC - 1));
      gap_end   = (tmr_q == TMR_W'(GAP_CYC - 1));
      last_cell = (idx_q == IDX_W'(NUM_BITS - 1));

      if (clr_i) begin
         active_d = 1'b0;
         pulse_d  = 1'b0;
         idx_d    = '0;
         tmr_d    = '0;
         wl_d     = '0;
      end else if (go_i) begin
         active_d = 1'b1;
         pulse_d  = 1'b1;
         idx_d    = '0;
         tmr_d    = '0;
         wl_d     = NUM_BITS'(1);
      end else if (active_q) begin
         if (pulse_q) begin
            if (pulse_end) begin
               pulse_d = 1'b0;
               tmr_d   = '0;
               wl_d    = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end else if (gap_end) begin
            tmr_d = '0;
            if (last_cell) begin
               active_d = 1'b0;
               idx_d    = '0;
            end else begin
               idx_d   = idx_nxt;
               pulse_d = 1'b1;
               wl_d    = NUM_BITS'(1) << idx_nxt;
            end
         end else begin
            tmr_d = tmr_q + TMR_W'(1);
         end
      end
   end

   assign wl_o          = wl_q;
   assign last_done_c_o = active_q & ~pulse_q & gap_end & last_cell;

endmodule

// File: rtl/fle_cfg_bank_loader.sv
// Tile config loader: collects a serial bitstream into the bl image, then writes it cell by cell via wl pulses.
module fle_cfg_bank_loader
   import fle_cfg_pkg::*;
#(
   parameter int unsigned NUM_BITS     = FLE_CFG_BITS,
   parameter int unsigned BL_SETUP_CYC = 1,
   parameter int unsigned WL_PULSE_CYC = 2,
   parameter int unsigned WL_GAP_CYC   = 1
) (
   input  logic                prog_clk,
   input  logic                prog_reset,
   input  logic                start,
   input  logic                abort,
   input  logic                cfg_bit,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   output logic [NUM_BITS-1:0] bl,
   output logic [NUM_BITS-1:0] wl,
   output logic                busy,
   output logic                done,
   output logic                aborted
);

   localparam int unsigned BIT_W = cnt_width(NUM_BITS);
   localparam int unsigned SET_W = cnt_width(BL_SETUP_CYC);

   state_e              state_q, state_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [SET_W-1:0]    setup_cnt_q, setup_cnt_d;
   logic [NUM_BITS-1:0] bl_q, bl_d;
   logic                cfg_ready_q, cfg_ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                aborted_q, aborted_d;
   logic                xfer;
   logic                busy_state;
   logic                seq_go;
   logic                seq_clr;
   logic                seq_last_done;

   // State and registered outputs
   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         setup_cnt_q <= '0;
         bl_q        <= '0;
         cfg_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         setup_cnt_q <= setup_cnt_d;
         bl_q        <= bl_d;
         cfg_ready_q <= cfg_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         aborted_q   <= aborted_d;
      end
   end

   // Next state, bl capture and output decode; abort out of any busy state beats everything else
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      setup_cnt_d = setup_cnt_q;
      bl_d        = bl_q;
      aborted_d   = 1'b0;
      seq_go      = 1'b0;
      seq_clr     = 1'b0;
      xfer        = cfg_valid & cfg_ready_q;
      busy_state  = (state_q == LOAD) || (state_q == SETUP) || (state_q == WRITE);

      if (abort && busy_state) begin
         state_d   = IDLE;
         aborted_d = 1'b1;
         seq_clr   = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start && !abort) begin
                  state_d   = LOAD;
                  bit_cnt_d = '0;
               end
            end
            LOAD: begin
               if (xfer) begin
                  bl_d[bit_cnt_q] = cfg_bit;
                  if (bit_cnt_q == BIT_W'(NUM_BITS - 1)) begin
                     state_d     = SETUP;
                     bit_cnt_d   = '0;
                     setup_cnt_d = '0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  end
               end
            end
            SETUP: begin
               if (setup_cnt_q == SET_W'(BL_SETUP_CYC - 1)) begin
                  state_d     = WRITE;
                  seq_go      = 1'b1;
                  setup_cnt_d = '0;
               end else begin
                  setup_cnt_d = setup_cnt_q + SET_W'(1);
               end
            end
            WRITE: begin
               if (seq_last_done) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      cfg_ready_d = (state_d == LOAD);
      busy_d      = (state_d == LOAD) || (state_d == SETUP) || (state_d == WRITE);
      done_d      = (state_d == DONE);
   end

   // Word-line walker
   fle_cfg_wl_sequencer #(
      .NUM_BITS  (NUM_BITS),
      .PULSE_CYC (WL_PULSE_CYC),
      .GAP_CYC   (WL_GAP_CYC)
   ) u_wl_seq (
      .clk_i         (prog_clk),
      .rst_i         (prog_reset),
      .go_i          (seq_go),
      .clr_i         (seq_clr),
      .wl_o          (wl),
      .last_done_c_o (seq_last_done)
   );

   assign cfg_ready = cfg_ready_q;
   assign bl        = bl_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign aborted   = aborted_q;

endmodule

// File: tb/tb_fle_cfg_bank_loader.sv
// Randomized self-checking bench for fle_cfg_bank_loader against a cycle-offset timing model.
module tb_fle_cfg_bank_loader;

   localparam int unsigned NB = 70;
   localparam int SETUP    = 1;
   localparam int PULSE    = 2;
   localparam int GAP      = 1;
   localparam int FIRST_WL = 1 + SETUP;
   localparam int PERIOD   = PULSE + GAP;
   localparam int DONE_C   = FIRST_WL + NB * PERIOD;

   logic          prog_clk   = 1'b0;
   logic          prog_reset = 1'b1;
   logic          start      = 1'b0;
   logic          abort      = 1'b0;
   logic          cfg_bit    = 1'b0;
   logic          cfg_valid  = 1'b0;
   logic          cfg_ready;
   logic [NB-1:0] bl;
   logic [NB-1:0] wl;
   logic          busy;
   logic          done;
   logic          aborted;

   int            checks   = 0;
   int            failures = 0;
   logic [NB-1:0] model_bl;
   logic [NB-1:0] pat_img;
   logic [NB-1:0] img;

   always #5 prog_clk = ~prog_clk;

   fle_cfg_bank_loader #(
      .NUM_BITS     (NB),
      .BL_SETUP_CYC (SETUP),
      .WL_PULSE_CYC (PULSE),
      .WL_GAP_CYC   (GAP)
   ) dut (
      .prog_clk   (prog_clk),
      .prog_reset (prog_reset),
      .start      (start),
      .abort      (abort),
      .cfg_bit    (cfg_bit),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .bl         (bl),
      .wl         (wl),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted)
   );

   // Single comparison point
   task automatic chk(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected wl for cycle c after the last accepted bit (c=1 is the first cycle after it)
   function automatic logic [NB-1:0] exp_wl(input int c);
      logic [NB-1:0] v;
      v = '0;
      if (c >= FIRST_WL && c < DONE_C && ((c - FIRST_WL) % PERIOD) < PULSE)
         v[(c - FIRST_WL) / PERIOD] = 1'b1;
      return v;
   endfunction

   function automatic logic [NB-1:0] rand_img();
      logic [NB-1:0] v;
      for (int i = 0; i < int'(NB); i++) v[i] = 1'($urandom_range(1, 0));
      return v;
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, " wl"},    wl, '0);
      chk({tag, " busy"},  NB'(busy), '0);
      chk({tag, " ready"}, NB'(cfg_ready), '0);
      chk({tag, " done"},  NB'(done), '0);
   endtask

   // Start a load and stream an image; optional random valid gaps and a stray start at bit start_bit
   task automatic load_image(input logic [NB-1:0] im, input int max_gap, input int start_bit);
      int gap;
      start = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
      for (int i = 0; i < int'(NB); i++) begin
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         for (int g = 0; g < gap; g++) begin
            cfg_valid = 1'b0;
            start     = 1'b0;
            @(negedge prog_clk);
            chk("stall busy", NB'(busy), NB'(1'b1));
         end
         chk($sformatf("ready bit %0d", i), NB'(cfg_ready), NB'(1'b1));
         cfg_valid = 1'b1;
         cfg_bit   = im[i];
         start     = (i == start_bit);
         @(negedge prog_clk);
      end
      cfg_valid = 1'b0;
      start     = 1'b0;
      model_bl  = im;
   endtask

   // Follow SETUP/WRITE/DONE cycle by cycle; may pulse start at cycle start_at
   task automatic watch_write(input int stop_c, input int start_at);
      for (int c = 1; c <= stop_c; c++) begin
         chk($sformatf("wl c=%0d", c), wl, exp_wl(c));
         chk($sformatf("busy c=%0d", c), NB'(busy), NB'(c < DONE_C));
         chk($sformatf("done c=%0d", c), NB'(done), NB'(c == DONE_C));
         chk($sformatf("ready c=%0d", c), NB'(cfg_ready), '0);
         chk($sformatf("aborted c=%0d", c), NB'(aborted), '0);
         if (c == 1 || c == DONE_C) chk($sformatf("bl c=%0d", c), bl, model_bl);
         start = (c == start_at);
         if (c < stop_c) @(negedge prog_clk);
      end
      start = 1'b0;
   endtask

   initial begin
      // Reset held for three cycles, then idle with no start
      prog_reset = 1'b1;
      repeat (3) begin
         @(negedge prog_clk);
         chk_idle("reset");
         chk("reset bl", bl, '0);
         chk("reset aborted", NB'(aborted), '0);
      end
      prog_reset = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge prog_clk);
         chk_idle("idle");
      end

      // Nominal back-to-back stream, pattern bit i = (i % 3 == 0)
      for (int i = 0; i < int'(NB); i++) pat_img[i] = (i % 3 == 0);
      load_image(pat_img, 0, -1);
      watch_write(DONE_C + 1, 0);

      // Stalled streams: random image, then the nominal pattern again
      img = rand_img();
      load_image(img, 10, -1);
      watch_write(DONE_C + 1, 0);
      load_image(pat_img, 10, -1);
      watch_write(DONE_C + 1, 0);
      chk("stalled bl equals nominal", bl, pat_img);

      // Stray start during LOAD and during WRITE
      img = rand_img();
      load_image(img, 3, 35);
      watch_write(DONE_C + 1, 100);
      for (int k = 0; k < 5; k++) begin
         @(negedge prog_clk);
         chk_idle("post stray start");
      end

      // Abort while wl[30] is high, then a full all-ones load
      img = rand_img();
      load_image(img, 0, -1);
      watch_write(FIRST_WL + PERIOD * 30, 0);
      abort = 1'b1;
      @(negedge prog_clk);
      abort = 1'b0;
      chk("abort wl", wl, '0);
      chk("abort pulse", NB'(aborted), NB'(1'b1));
      chk("abort done", NB'(done), '0);
      chk("abort busy", NB'(busy), '0);
      chk("abort ready", NB'(cfg_ready), '0);
      chk("abort bl kept", bl, model_bl);
      for (int k = 0; k < 250; k++) begin
         @(negedge prog_clk);
         chk_idle("after abort");
         chk("after abort pulse", NB'(aborted), '0);
      end
      load_image({NB{1'b1}}, 0, -1);
      watch_write(DONE_C + 1, 0);
      chk("all ones bl", bl, {NB{1'b1}});

      // start and abort together in IDLE
      start = 1'b1;
      abort = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
      abort = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk_idle("start+abort idle");
         chk("start+abort aborted", NB'(aborted), '0);
         @(negedge prog_clk);
      end

      // Asynchronous reset between edges while wl[40] is high
      img = rand_img();
      load_image(img, 0, -1);
      watch_write(FIRST_WL + PERIOD * 40, 0);
      #2 prog_reset = 1'b1;
      #1;
      chk("async reset wl", wl, '0);
      chk("async reset busy", NB'(busy), '0);
      chk("async reset bl", bl, '0);
      @(negedge prog_clk);
      prog_reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge prog_clk);
         chk_idle("after async reset");
      end

      // Recovery after reset: a fresh random load completes normally
      img = rand_img();
      load_image(img, 2, -1);
      watch_write(DONE_C + 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
